// File: rtl/branch_hazard_ctrl.sv
// rtl/branch_hazard_ctrl.sv - ID-stage branch/load hazard sequencer with stall, flush and perf counters
// Resolves load-to-branch and load-use hazards by stalling IF/ID, then commits branch/jump redirects.
module branch_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             IF_ID_Branch,
    input  logic             IF_ID_Bne,
    input  logic             IF_ID_Jump,
    input  logic             IF_ID_UseRs,
    input  logic             IF_ID_UseRt,
    input  logic [4:0]       IF_ID_rs,
    input  logic [4:0]       IF_ID_rt,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_rd,
    input  logic             EX_MEM_MemRead,
    input  logic [4:0]       EX_MEM_rd,
    input  logic             cmp_equal,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             ID_EX_Bubble,
    output logic             PCSrc,
    output logic             IF_Flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t     state;
    logic [1:0] left;

    logic       is_branch;
    logic       hit_ex_rs, hit_ex_rt, hit_mem_rs, hit_mem_rt;
    logic       load_ex_hit, load_mem_hit;
    logic [1:0] demand;
    logic       taken;
    logic       stall_now;
    logic       taken_now;

    // A jump that arrives together with a branch is handled as a non-branch.
    assign is_branch = IF_ID_Branch && !IF_ID_Jump;

    assign hit_ex_rs  = IF_ID_UseRs && (IF_ID_rs == ID_EX_rd)  && (ID_EX_rd  != 5'd0);
    assign hit_ex_rt  = IF_ID_UseRt && (IF_ID_rt == ID_EX_rd)  && (ID_EX_rd  != 5'd0);
    assign hit_mem_rs = IF_ID_UseRs && (IF_ID_rs == EX_MEM_rd) && (EX_MEM_rd != 5'd0);
    assign hit_mem_rt = IF_ID_UseRt && (IF_ID_rt == EX_MEM_rd) && (EX_MEM_rd != 5'd0);

    assign load_ex_hit  = ID_EX_MemRead  && (hit_ex_rs  || hit_ex_rt);
    assign load_mem_hit = EX_MEM_MemRead && (hit_mem_rs || hit_mem_rt);

    // Non-load producers are covered by forwarding; only loads generate demand.
    always_comb begin
        demand = 2'd0;
        if (is_branch) begin
            if (load_ex_hit)
                demand = 2'd2;
            else if (load_mem_hit)
                demand = 2'd1;
        end else if (load_ex_hit) begin
            demand = 2'd1;
        end
    end

    assign taken = IF_ID_Jump || (IF_ID_Branch && (cmp_equal ^ IF_ID_Bne));

    assign stall_now = !rst && ((state == STALL) || (demand != 2'd0));
    assign taken_now = !rst && (state == RUN) && (demand == 2'd0) && taken;

    always_comb begin
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        ID_EX_Bubble = 1'b0;
        PCSrc        = 1'b0;
        IF_Flush     = 1'b0;
        if (stall_now) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
        end else if (taken_now) begin
            PCSrc    = 1'b1;
            IF_Flush = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            left      <= 2'd0;
            stall_cnt <= '0;
            taken_cnt <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (demand == 2'd2) begin
                        state <= STALL;
                        left  <= 2'd1;
                    end
                end
                STALL: begin
                    left <= left - 2'd1;
                    if (left <= 2'd1) begin
                        state <= RUN;
                        left  <= 2'd0;
                    end
                end
                default: begin
                    state <= RUN;
                    left  <= 2'd0;
                end
            endcase
            if (stall_now)
                stall_cnt <= stall_cnt + 1'b1;
            if (taken_now)
                taken_cnt <= taken_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// tb/tb_branch_hazard_ctrl.sv - scoreboard bench for branch_hazard_ctrl against a cycle-level reference model
module tb_branch_hazard_ctrl;

    localparam int CNT_W = 16;
    localparam int MODW  = 1 << CNT_W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             IF_ID_Branch = 1'b0, IF_ID_Bne = 1'b0, IF_ID_Jump = 1'b0;
    logic             IF_ID_UseRs = 1'b0, IF_ID_UseRt = 1'b0;
    logic [4:0]       IF_ID_rs = 5'd0, IF_ID_rt = 5'd0;
    logic             ID_EX_MemRead = 1'b0, EX_MEM_MemRead = 1'b0;
    logic [4:0]       ID_EX_rd = 5'd0, EX_MEM_rd = 5'd0;
    logic             cmp_equal = 1'b0;
    logic             PCWrite, IF_ID_Write, ID_EX_Bubble, PCSrc, IF_Flush;
    logic [CNT_W-1:0] stall_cnt, taken_cnt;

    branch_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .IF_ID_Branch(IF_ID_Branch), .IF_ID_Bne(IF_ID_Bne), .IF_ID_Jump(IF_ID_Jump),
        .IF_ID_UseRs(IF_ID_UseRs), .IF_ID_UseRt(IF_ID_UseRt),
        .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt),
        .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rd(ID_EX_rd),
        .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_rd(EX_MEM_rd),
        .cmp_equal(cmp_equal),
        .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .ID_EX_Bubble(ID_EX_Bubble),
        .PCSrc(PCSrc), .IF_Flush(IF_Flush),
        .stall_cnt(stall_cnt), .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       branch, bne, jump, use_rs, use_rt;
        bit [4:0] rs, rt;
        bit       idex_mr;
        bit [4:0] idex_rd;
        bit       exmem_mr;
        bit [4:0] exmem_rd;
        bit       cmp;
    } stim_t;

    typedef struct {
        bit [4:0] ctl;   // {PCWrite, IF_ID_Write, ID_EX_Bubble, PCSrc, IF_Flush}
        int       sc;
        int       tc;
        string    tag;
    } exp_t;

    localparam bit [4:0] CTL_DEF   = 5'b11000;
    localparam bit [4:0] CTL_STALL = 5'b00100;
    localparam bit [4:0] CTL_TAKEN = 5'b11011;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: outstanding forced stall cycles plus the two counters.
    int   m_pending = 0;
    int   m_sc      = 0;
    int   m_tc      = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int stall_demand(input stim_t s);
        bit ex_hit, mem_hit;
        ex_hit  = s.idex_mr && ((s.use_rs && s.rs == s.idex_rd && s.idex_rd != 0) ||
                                (s.use_rt && s.rt == s.idex_rd && s.idex_rd != 0));
        mem_hit = s.exmem_mr && ((s.use_rs && s.rs == s.exmem_rd && s.exmem_rd != 0) ||
                                 (s.use_rt && s.rt == s.exmem_rd && s.exmem_rd != 0));
        if (s.branch && !s.jump)
            return ex_hit ? 2 : (mem_hit ? 1 : 0);
        return ex_hit ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_pending = 0;
        m_sc      = 0;
        m_tc      = 0;
    endtask

    task automatic step(input bit r, input stim_t s, input string tag);
        exp_t e;
        int   d;
        @(posedge clk);
        #1;
        IF_ID_Branch = s.branch;  IF_ID_Bne = s.bne;  IF_ID_Jump = s.jump;
        IF_ID_UseRs = s.use_rs;   IF_ID_UseRt = s.use_rt;
        IF_ID_rs = s.rs;          IF_ID_rt = s.rt;
        ID_EX_MemRead = s.idex_mr;   ID_EX_rd = s.idex_rd;
        EX_MEM_MemRead = s.exmem_mr; EX_MEM_rd = s.exmem_rd;
        cmp_equal = s.cmp;
        rst = r;
        e.tag = tag;
        if (r) begin
            model_reset();
            e.ctl = CTL_DEF;
            e.sc  = 0;
            e.tc  = 0;
        end else begin
            e.sc = m_sc;
            e.tc = m_tc;
            d = stall_demand(s);
            if (m_pending > 0 || d > 0) begin
                e.ctl = CTL_STALL;
                m_sc  = (m_sc + 1) % MODW;
                m_pending = (m_pending > 0) ? m_pending - 1 : d - 1;
            end else if (s.jump || (s.branch && (s.cmp ^ s.bne))) begin
                e.ctl = CTL_TAKEN;
                m_tc  = (m_tc + 1) % MODW;
            end else begin
                e.ctl = CTL_DEF;
            end
        end
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() != 0) begin
                e = q.pop_front();
                check({e.tag, "_ctl"}, int'({PCWrite, IF_ID_Write, ID_EX_Bubble, PCSrc, IF_Flush}), int'(e.ctl));
                check({e.tag, "_stall_cnt"}, int'(stall_cnt), e.sc);
                check({e.tag, "_taken_cnt"}, int'(taken_cnt), e.tc);
            end
        end
    end

    function automatic stim_t nop();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    function automatic bit [4:0] pick_reg();
        case ($urandom_range(0, 4))
            0:       return 5'd0;
            1:       return 5'd5;
            2:       return 5'd9;
            3:       return 5'd16;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    initial begin : stimulus
        stim_t s;
        step(1, nop(), "reset0");
        step(1, nop(), "reset1");
        step(0, nop(), "idle");

        // lw $s0 ; beq $s0,$s1 : two stalls, then taken resolve
        s = nop(); s.branch = 1; s.use_rs = 1; s.use_rt = 1; s.rs = 16; s.rt = 17;
        s.idex_mr = 1; s.idex_rd = 16;
        step(1, nop(), "t1_rst");
        step(0, s, "t1_c1");
        step(0, s, "t1_c2");
        s.idex_mr = 0; s.idex_rd = 0; s.cmp = 1;
        step(0, s, "t1_c3");
        step(0, nop(), "t1_after");
        @(negedge clk); #1;
        check("t1_stall_cnt_const", int'(stall_cnt), 2);
        check("t1_taken_cnt_const", int'(taken_cnt), 1);

        // load in MEM, bne rt=9, equal operands: one stall then not taken
        s = nop(); s.branch = 1; s.bne = 1; s.use_rs = 1; s.use_rt = 1; s.rs = 3; s.rt = 9;
        s.exmem_mr = 1; s.exmem_rd = 9; s.cmp = 1;
        step(0, s, "t2_c1");
        s.exmem_mr = 0;
        step(0, s, "t2_c2");

        // ALU producer then beq: no stall, same-cycle resolve
        s = nop(); s.branch = 1; s.use_rs = 1; s.use_rt = 1; s.rs = 8; s.rt = 8;
        s.idex_rd = 8; s.cmp = 1;
        step(0, s, "t3_alu_branch");

        // load to $zero then branch on $zero: no stall
        s = nop(); s.branch = 1; s.use_rs = 1; s.use_rt = 1; s.idex_mr = 1; s.cmp = 0;
        step(0, s, "t4_zero");

        // load rd=5 then add with rt=5: one stall; with UseRt=0 none
        s = nop(); s.use_rs = 1; s.use_rt = 1; s.rs = 2; s.rt = 5; s.idex_mr = 1; s.idex_rd = 5;
        step(0, s, "t5_use");
        s.idex_mr = 0;
        step(0, s, "t5_after");
        s.idex_mr = 1; s.use_rt = 0;
        step(0, s, "t5_nouse");

        // reset pulsed inside the first cycle of a 2-cycle stall
        s = nop(); s.branch = 1; s.use_rs = 1; s.rs = 16; s.idex_mr = 1; s.idex_rd = 16;
        step(0, s, "t6_stall");
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("t6_rst_ctl", int'({PCWrite, IF_ID_Write, ID_EX_Bubble, PCSrc, IF_Flush}), int'(CTL_DEF));
        check("t6_rst_stall_cnt", int'(stall_cnt), 0);
        check("t6_rst_taken_cnt", int'(taken_cnt), 0);
        model_reset();
        step(1, s, "t6_held");
        step(0, nop(), "t6_release");
        step(0, nop(), "t6_release2");

        // randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            s.branch   = ($urandom_range(0, 2) == 0);
            s.bne      = $urandom_range(0, 1);
            s.jump     = ($urandom_range(0, 7) == 0);
            s.use_rs   = $urandom_range(0, 3) != 0;
            s.use_rt   = $urandom_range(0, 1);
            s.rs       = pick_reg();
            s.rt       = pick_reg();
            s.idex_mr  = $urandom_range(0, 1);
            s.idex_rd  = pick_reg();
            s.exmem_mr = $urandom_range(0, 1);
            s.exmem_rd = pick_reg();
            s.cmp      = $urandom_range(0, 1);
            step(($urandom_range(0, 99) == 0), s, "rand");
        end

        // 2^CNT_W consecutive load-use stalls wrap stall_cnt to 0
        step(1, nop(), "wrap_rst");
        s = nop(); s.use_rs = 1; s.rs = 7; s.idex_mr = 1; s.idex_rd = 7;
        for (int i = 0; i < MODW; i++)
            step(0, s, "wrap");
        step(0, nop(), "wrap_end");
        @(negedge clk); #1;
        check("wrap_stall_cnt_const", int'(stall_cnt), 0);

        for (int i = 0; i < 10 && q.size() != 0; i++)
            @(posedge clk);
        check("drain_queue_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_hazard_ctrl.md
# branch_hazard_ctrl

Pipeline hazard sequencer for the 5-stage MIPS core with branch resolution in ID. Detects load-to-branch and load-use hazards that EX/MEM→ID control forwarding cannot cover, stalls IF/ID for the required number of cycles, then commits the branch decision and flushes the IF slot when the branch is taken or a jump is decoded. Sits beside the ID-stage comparator and drives PC, IF/ID and ID/EX register enables. Also keeps wrapping performance counters.

## Interface
- CNT_W, 16, width of the performance counters
- clk  in  1  pipeline clock, rising edge
- rst  in  1  asynchronous, active-high reset
- IF_ID_Branch  in  1  conditional branch in ID
- IF_ID_Bne  in  1  branch is bne (0 = beq); valid with IF_ID_Branch
- IF_ID_Jump  in  1  j/jal in ID
- IF_ID_UseRs, IF_ID_UseRt  in  1 each  ID instruction reads rs / rt
- IF_ID_rs, IF_ID_rt  in  5 each  ID source registers
- ID_EX_MemRead  in  1  load in EX
- ID_EX_rd  in  5  destination of EX instruction
- EX_MEM_MemRead  in  1  load in MEM
- EX_MEM_rd  in  5  destination of MEM instruction
- cmp_equal  in  1  ID comparator result (forwarded operands)
- PCWrite  out  1  PC enable
- IF_ID_Write  out  1  IF/ID enable
- ID_EX_Bubble  out  1  zero ID/EX control fields
- PCSrc  out  1  select branch/jump target
- IF_Flush  out  1  clear IF/ID at next edge
- stall_cnt  out  CNT_W  stall cycles since reset
- taken_cnt  out  CNT_W  taken branches + jumps since reset

## Operation
- Match(r, d) = r == d and d != 0 and the operand is used (UseRs/UseRt). Register 0 never creates a hazard.
- Stall demand, evaluated only in RUN:
  - Branch, Match with ID_EX_rd, ID_EX_MemRead=1: 2 cycles; load data is not yet available at EX/MEM.
  - Branch, Match with EX_MEM_rd, EX_MEM_MemRead=1: 1 cycle.
  - Non-branch (incl. jump-register-free ops), Match with ID_EX_rd, ID_EX_MemRead=1: 1 cycle (classic load-use).
  - Non-load producers are not stalled. Control/data forwarding covers them.
  - Several matches (rs and rt, or EX and MEM): take the maximum demand.
- FSM states: RUN and STALL, plus a 2-bit down-counter `left`.
  - RUN, demand n>0: assert stall outputs this cycle. If n=2, next state STALL with left=1; if n=1, stay in RUN. Hazard logic is re-evaluated next cycle against the advanced pipeline.
  - STALL: assert stall outputs and decrement `left`. When left reaches 1, next state RUN. Demand inputs are ignored in STALL.
- Stall outputs: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, PCSrc=0, IF_Flush=0.
- Resolve, in RUN with demand 0:
  - taken = Jump or (Branch and (cmp_equal xor Bne)).
  - taken=1: PCSrc=1, IF_Flush=1, PCWrite=1, IF_ID_Write=1, ID_EX_Bubble=0.
  - Otherwise all outputs are at their defaults.
- Defaults: PCWrite=1, IF_ID_Write=1, ID_EX_Bubble=0, PCSrc=0, IF_Flush=0.
- Counters: stall_cnt +1 every cycle with stall outputs asserted. taken_cnt +1 every resolve cycle with taken=1. Both wrap modulo 2^CNT_W, with no saturation.
- Jump together with a branch-qualified hazard cannot occur, because the decoder guarantees Branch and Jump are exclusive. If both are asserted anyway, Jump is treated as a non-branch.

## Timing
- Control outputs are combinational from state and inputs and are valid in the same cycle. State and counters update on the rising clk edge.
- rst asserted, at any time including mid-stall: state=RUN, left=0, counters=0, control outputs forced to defaults while rst is high. The first decision happens on the first edge after release.
- Branch behind a load in EX: 2 stall cycles, then resolve on the 3rd cycle.
- Branch behind a load in MEM: 1 stall cycle.
- Load-use on a non-branch: 1 stall cycle.
- Taken resolve costs 1 flushed slot. A not-taken resolve costs 0.
- Counter update for a cycle is visible the following cycle.

## Test plan
- lw $s0 then beq $s0,$s1 (rs=16, ID_EX_rd=16, ID_EX_MemRead=1), cmp_equal=1 on the 3rd cycle:
  - Required: 2 cycles of PCWrite=0 and ID_EX_Bubble=1, then PCSrc=1 and IF_Flush=1 for 1 cycle.
  - Required: stall_cnt=2 and taken_cnt=1 afterwards.
- Load in MEM with EX_MEM_rd=9 and bne rt=9, cmp_equal=1:
  - Required: 1 stall cycle, then a not-taken resolve with PCSrc=0 and taken_cnt unchanged.
- add $t0 followed by beq $t0 (ID_EX_MemRead=0):
  - Required: no stall; the branch resolves in the same cycle.
- Load with rd=0 followed by a branch on $zero:
  - Required: no stall.
- Load rd=5 followed by add using rt=5:
  - Required: exactly 1 stall cycle.
  - Repeat with UseRt=0: no stall required.
- rst pulsed during the 1st cycle of a 2-cycle stall:
  - Required: outputs return to defaults immediately, counters read 0, and there is no residual stall after release.
- Drive 2^CNT_W (65536) stall cycles:
  - Required: stall_cnt wraps to 0.
